// File: rtl/kogge_stone_arb.sv
// rtl/kogge_stone_arb.sv - round-robin arbiter sharing one Kogge-Stone adder among R requesters
// Holds one registered result; a new grant is issued only when that slot is free or draining.

module kogge_stone #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N-1:0] p0;
   logic [N-1:0] g;
   logic [N-1:0] p;
   logic [N-1:0] gn;
   logic [N-1:0] pn;

   // Prefix tree: after the last level g[i] is the carry out of bits [i:0].
   always_comb begin
      p0 = a ^ b;
      g  = a & b;
      p  = p0;
      gn = '0;
      pn = '0;
      for (int d = 1; d < N; d = d * 2) begin
         gn = g;
         pn = p;
         for (int i = d; i < N; i++) begin
            gn[i] = g[i] | (p[i] & g[i-d]);
            pn[i] = p[i] & p[i-d];
         end
         g = gn;
         p = pn;
      end
   end

   assign sum  = p0 ^ {g[N-2:0], 1'b0};
   assign cout = g[N-1];

endmodule

module kogge_stone_arb #(
   parameter int N   = 32,
   parameter int R   = 4,
   parameter int IDW = $clog2(R)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [R-1:0]     req_valid,
   output logic [R-1:0]     req_ready,
   input  logic [R*N-1:0]   req_a,
   input  logic [R*N-1:0]   req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [N-1:0]     rsp_sum,
   output logic             rsp_cout,
   output logic [IDW-1:0]   rsp_id,
   output logic             busy
);

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] win;
   logic [IDW-1:0] idx;
   logic [IDW-1:0] nxt;
   logic           found;
   logic           slot_free;
   logic           accept;
   logic [N-1:0]   op_a;
   logic [N-1:0]   op_b;
   logic [N-1:0]   add_sum;
   logic           add_cout;

   // First valid requester at or after ptr, wrapping.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < R; k++) begin
         idx = IDW'((int'(ptr) + k) % R);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign slot_free = !rsp_valid || rsp_ready;
   assign accept    = rst_n && found && slot_free;
   assign req_ready = accept ? (R'(1) << win) : '0;
   assign nxt       = (win == IDW'(R - 1)) ? '0 : win + 1'b1;
   assign busy      = rsp_valid || (|req_valid);

   assign op_a = req_a[win*N +: N];
   assign op_b = req_b[win*N +: N];

   kogge_stone #(.N(N)) u_add (
      .a    (op_a),
      .b    (op_b),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         rsp_valid <= 1'b0;
         rsp_sum   <= '0;
         rsp_cout  <= 1'b0;
         rsp_id    <= '0;
      end else if (accept) begin
         ptr       <= nxt;
         rsp_valid <= 1'b1;
         rsp_sum   <= add_sum;
         rsp_cout  <= add_cout;
         rsp_id    <= win;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: doc/kogge_stone_arb.md
Name: kogge_stone_arb

Overview:
- Shares one N-bit kogge_stone adder instance among R requesters.
- Each requester uses a valid/ready handshake; grants rotate round-robin.
- The registered result carries the requester ID and is returned on a single valid/ready response port.
- Sits between the PE issue stages and the shared address/ALU add resource.

Parameters:
- N, 32: operand width passed to the kogge_stone instance.
- R, 4: number of requesters, R >= 2.
- IDW, $clog2(R): width of the requester ID field.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  R  per-requester operand valid
- req_ready  output  R  per-requester accept, one-hot or zero
- req_a  input  R*N  packed operand A; requester i occupies bits [i*N +: N]
- req_b  input  R*N  packed operand B, same packing
- rsp_valid  output  1  result register holds a valid result
- rsp_ready  input  1  downstream consumes the result
- rsp_sum  output  N  registered sum
- rsp_cout  output  1  registered carry-out
- rsp_id  output  IDW  index of the requester that produced the result
- busy  output  1  rsp_valid OR any req_valid

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0.
  - Round-robin pointer ptr=0.
  - req_ready=0 while rst_n is low.
- Slot availability: slot_free = !rsp_valid | rsp_ready. Combinational; downstream drain in the same cycle frees the slot.
- Arbitration (combinational each cycle):
  - Search req_valid starting at index ptr, wrapping modulo R.
  - The first set bit is winner w.
  - req_ready[w] = slot_free; all other req_ready bits are 0.
  - If no req_valid is set, req_ready=0.
- Accept occurs when req_valid[w] & req_ready[w]. On the clock edge that follows an accept:
  - rsp_sum / rsp_cout load the adder outputs for req_a[w] + req_b[w].
  - rsp_id=w, rsp_valid=1.
  - ptr = (w+1) mod R; wraps R-1 -> 0.
- Latency: 1 cycle from accept to rsp_valid. Throughput is 1 result/cycle while rsp_ready is held high.
- Drain: rsp_valid & rsp_ready with no new accept clears rsp_valid on the next edge. rsp_sum/cout/id hold their last values.
- Simultaneous drain and accept: the register loads the new result and rsp_valid stays 1 (no bubble).
- Stall: rsp_valid=1 & rsp_ready=0 forces req_ready=0.
  - rsp_sum/cout/id and ptr hold.
  - Held response must be stable until consumed.
- ptr advances only on an accept, never on idle or stalled cycles.
- Requester obligations (SVA checks in the bench, not enforced in RTL):
  - req_valid must not drop without a handshake.
  - req_a/req_b must stay stable while req_valid is held.
- Fairness: a continuously asserted requester is granted within R accepts.
- Arithmetic:
  - Unsigned N-bit add with no carry-in.
  - rsp_sum = (a+b) mod 2^N.
  - rsp_cout = bit N of the full sum.
  - The datapath is exactly one kogge_stone #(.N(N)) instance, fed through an R:1 operand mux selected by w.
- Reset mid-operation: a pending result is discarded (rsp_valid=0) and ptr returns to 0. After release, arbitration restarts from requester 0.

Test Plan:
- Reset: assert rst_n=0 with rsp_valid=1 pending -> rsp_valid, rsp_sum, rsp_id and req_ready all 0 immediately, before the next clk edge.
- Single requester: req_valid=4'b0100, a=32'hFFFF_FFFF, b=32'h0000_0001, rsp_ready=1 -> req_ready=4'b0100. Next cycle: rsp_valid=1, rsp_sum=0, rsp_cout=1, rsp_id=2.
- Round-robin: all four requesters valid continuously, rsp_ready=1, requester i sends a=i, b=10 -> rsp_id sequence 0,1,2,3,0,…, one result per cycle, rsp_sum=10+i.
- Backpressure: rsp_valid=1, rsp_ready=0 for 5 cycles with req_valid=4'b1111 -> req_ready=0 and rsp_* stable throughout. On release, next grant is (held rsp_id+1) mod 4.
- Simultaneous drain+accept: rsp_valid=1, rsp_ready=1, req_valid[1]=1 with a=32'h8000_0000, b=32'h8000_0000 -> rsp_valid stays 1 with no bubble; new rsp_sum=0, rsp_cout=1, rsp_id=1.
- Random: 10k cycles of random valid/ready against a golden model of 33-bit addition -> zero mismatches; no requester waits for more than 4 accepts.
